debounce_edge_detect: RTL and testbench

- Front-end conditioning stage that produces the clean data input for the sync-reset D flip-flop stage.
- Takes a raw asynchronous input (switch or button) and passes it through a SYNC_STAGES flip-flop synchronizer.
- Filters the synchronized signal with a consecutive-cycle debounce counter.
- Outputs the debounced level, its complement, one-cycle rise/fall pulses and a wrap-around count of accepted rising edges.

---
 rtl/debounce_edge_detect.sv | 86 ++++++++
 tb/tb_debounce_edge_detect.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/debounce_edge_detect.sv
// Raw-input conditioning stage: multi-flop synchronizer, consecutive-cycle debounce
// filter, registered rise/fall pulses and a wrapping count of accepted rising edges.
module debounce_edge_detect #(
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 16,
   parameter bit RESET_LEVEL     = 1'b0,
   parameter int EDGE_CNT_W      = 8
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  d_raw,
   output logic                  q,
   output logic                  q_not,
   output logic                  rise,
   output logic                  fall,
   output logic [EDGE_CNT_W-1:0] edge_count
);

   localparam int               CNT_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   s;
   logic                   mismatch;
   logic                   accept;

   logic [CNT_W-1:0]       cnt;
   logic [CNT_W-1:0]       cnt_next;
   logic                   q_next;
   logic                   rise_next;
   logic                   fall_next;
   logic [EDGE_CNT_W-1:0]  edge_count_next;

   // NOTE: the synchronizer flops are reset too, so a stale pre-reset level can
   // never leak into the filter right after release. State uses <= only.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync_q <= {SYNC_STAGES{RESET_LEVEL}};
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], d_raw};
      end
   end

   assign s        = sync_q[SYNC_STAGES-1];
   assign mismatch = s ^ q;
   assign accept   = mismatch && (cnt == CNT_LAST);

   always_comb begin
      // NOTE: every output gets a default first, so no branch can infer a latch.
      cnt_next        = '0;
      q_next          = q;
      rise_next       = 1'b0;
      fall_next       = 1'b0;
      edge_count_next = edge_count;

      if (accept) begin
         q_next    = s;
         rise_next = s;
         fall_next = ~s;
         if (s) begin
            edge_count_next = edge_count + EDGE_CNT_W'(1);
         end
      end else if (mismatch) begin
         cnt_next = cnt + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt        <= '0;
         q          <= RESET_LEVEL;
         rise       <= 1'b0;
         fall       <= 1'b0;
         edge_count <= '0;
      end else begin
         cnt        <= cnt_next;
         q          <= q_next;
         rise       <= rise_next;
         fall       <= fall_next;
         edge_count <= edge_count_next;
      end
   end

   assign q_not = ~q;

endmodule

// File: tb/tb_debounce_edge_detect.sv
// Bench for debounce_edge_detect: directed vector table, hand-written corner
// sequences and randomized stimulus against a sliding-window reference model.
`timescale 1us/1ns
module tb_debounce_edge_detect;

   localparam int SS = 2;
   localparam int DC = 4;
   localparam int EW = 2;
   localparam bit RL = 1'b0;

   logic          clk;
   logic          reset_n;
   logic          d_raw;
   logic          q;
   logic          q_not;
   logic          rise;
   logic          fall;
   logic [EW-1:0] edge_count;

   int n_checks = 0;
   int n_errors = 0;

   debounce_edge_detect #(
      .SYNC_STAGES    (SS),
      .DEBOUNCE_CYCLES(DC),
      .RESET_LEVEL    (RL),
      .EDGE_CNT_W     (EW)
   ) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .d_raw     (d_raw),
      .q         (q),
      .q_not     (q_not),
      .rise      (rise),
      .fall      (fall),
      .edge_count(edge_count)
   );

   initial clk = 1'b0;
   always #0.5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: q flips when the last DC synchronized samples all differ
   // from it; the synchronized sample is simply d_raw delayed by SS edges.
   bit          d_hist[$];
   bit          s_win[$];
   bit          m_q;
   bit          m_rise;
   bit          m_fall;
   bit          m_s_pre;
   bit          m_flip;
   int unsigned m_edges;

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         d_hist = {};
         for (int i = 0; i < SS; i++) d_hist.push_back(RL);
         s_win   = {};
         m_q     = RL;
         m_rise  = 1'b0;
         m_fall  = 1'b0;
         m_edges = 0;
      end else begin
         m_s_pre = d_hist[d_hist.size() - SS];
         d_hist.push_back(d_raw);
         if (d_hist.size() > 8) void'(d_hist.pop_front());
         s_win.push_back(m_s_pre);
         if (s_win.size() > DC) void'(s_win.pop_front());
         m_flip = (s_win.size() == DC);
         foreach (s_win[i]) if (s_win[i] == m_q) m_flip = 1'b0;
         m_rise = m_flip && !m_q;
         m_fall = m_flip && m_q;
         if (m_flip) begin
            m_q = !m_q;
            if (m_rise) m_edges++;
         end
      end
   end

   bit chk_en = 1'b0;
   int rise_seen = 0;

   always @(negedge clk) begin
      if (chk_en) begin
         check("model_q", q, m_q);
         check("model_q_not", q_not, !m_q);
         check("model_rise", rise, m_rise);
         check("model_fall", fall, m_fall);
         check("model_edge_count", edge_count, 32'(m_edges % (1 << EW)));
         check("rise_fall_exclusive", rise & fall, 0);
         if (rise === 1'b1) rise_seen++;
      end
   end

   initial begin
      #50000;
      $display("FAIL watchdog: simulation did not finish, checks %0d", n_checks);
      $fatal(1, "watchdog expired");
   end

   typedef struct {
      bit d;
      int cycles;
      bit q;
      bit rise;
      bit fall;
      int cnt;
   } vec_t;

   vec_t vecs[13];

   task automatic hold(input bit d, input int n);
      d_raw = d;
      repeat (n) @(negedge clk);
   endtask

   task automatic do_reset();
      @(negedge clk);
      #0.25 reset_n = 1'b0;
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
   endtask

   task automatic check_outs(input string tag, input bit eq, input bit er, input bit ef, input int ec);
      check({tag, "_q"}, q, eq);
      check({tag, "_q_not"}, q_not, !eq);
      check({tag, "_rise"}, rise, er);
      check({tag, "_fall"}, fall, ef);
      check({tag, "_edge_count"}, edge_count, 32'(ec % (1 << EW)));
   endtask

   int r0;
   int exp_cnt;
   int wrap_exp[5];

   initial begin
      vecs[0]  = '{d:1'b0, cycles:8, q:1'b0, rise:1'b0, fall:1'b0, cnt:0};
      vecs[1]  = '{d:1'b1, cycles:5, q:1'b0, rise:1'b0, fall:1'b0, cnt:0};
      vecs[2]  = '{d:1'b1, cycles:1, q:1'b1, rise:1'b1, fall:1'b0, cnt:1};
      vecs[3]  = '{d:1'b1, cycles:1, q:1'b1, rise:1'b0, fall:1'b0, cnt:1};
      vecs[4]  = '{d:1'b1, cycles:4, q:1'b1, rise:1'b0, fall:1'b0, cnt:1};
      vecs[5]  = '{d:1'b0, cycles:6, q:1'b0, rise:1'b0, fall:1'b1, cnt:1};
      vecs[6]  = '{d:1'b0, cycles:3, q:1'b0, rise:1'b0, fall:1'b0, cnt:1};
      vecs[7]  = '{d:1'b1, cycles:3, q:1'b0, rise:1'b0, fall:1'b0, cnt:1};
      vecs[8]  = '{d:1'b0, cycles:8, q:1'b0, rise:1'b0, fall:1'b0, cnt:1};
      vecs[9]  = '{d:1'b1, cycles:4, q:1'b0, rise:1'b0, fall:1'b0, cnt:1};
      vecs[10] = '{d:1'b0, cycles:2, q:1'b1, rise:1'b1, fall:1'b0, cnt:2};
      vecs[11] = '{d:1'b0, cycles:4, q:1'b0, rise:1'b0, fall:1'b1, cnt:2};
      vecs[12] = '{d:1'b0, cycles:3, q:1'b0, rise:1'b0, fall:1'b0, cnt:2};
      wrap_exp = '{1, 2, 3, 0, 1};

      reset_n = 1'b0;
      d_raw   = 1'b0;
      repeat (3) @(negedge clk);
      chk_en = 1'b1;
      check_outs("reset", 1'b0, 1'b0, 1'b0, 0);
      reset_n = 1'b1;

      // Clean edges, minimum-length pulse and a too-short pulse.
      for (int i = 0; i < 13; i++) begin
         hold(vecs[i].d, vecs[i].cycles);
         check_outs($sformatf("vec%0d", i), vecs[i].q, vecs[i].rise, vecs[i].fall, vecs[i].cnt);
      end
      exp_cnt = 2;

      // 2.5-cycle glitch is rejected and leaves the counter cleared.
      r0 = rise_seen;
      #0.25 d_raw = 1'b1;
      #2.5  d_raw = 1'b0;
      repeat (10) @(negedge clk);
      check_outs("glitch", 1'b0, 1'b0, 1'b0, exp_cnt);
      check("glitch_no_rise", rise_seen - r0, 0);
      hold(1'b1, 5);
      check("glitch_cnt_cleared_q", q, 1'b0);
      hold(1'b1, 1);
      exp_cnt++;
      check_outs("after_glitch", 1'b1, 1'b1, 1'b0, exp_cnt);

      // Falling edge leaves edge_count alone.
      hold(1'b1, 3);
      r0 = rise_seen;
      hold(1'b0, 6);
      check_outs("falling", 1'b0, 1'b0, 1'b1, exp_cnt);
      check("falling_no_rise", rise_seen - r0, 0);

      // Bounce: short random holds, then settle high; exactly one rise.
      hold(1'b0, 4);
      r0 = rise_seen;
      for (int i = 0; i < 5; i++) begin
         hold(i % 2 == 0, (i == 4) ? 12 : $urandom_range(1, 3));
      end
      exp_cnt++;
      check("bounce_q", q, 1'b1);
      check("bounce_one_rise", rise_seen - r0, 1);
      check("bounce_edge_count", edge_count, 32'(exp_cnt % (1 << EW)));

      // Reset two counts into a rising transition, then full latency again.
      hold(1'b0, 8);
      d_raw = 1'b1;
      repeat (4) @(posedge clk);
      #0.2 reset_n = 1'b0;
      #0.1 check_outs("reset_mid", 1'b0, 1'b0, 1'b0, 0);
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      repeat (5) @(negedge clk);
      check_outs("reset_mid_wait", 1'b0, 1'b0, 1'b0, 0);
      @(negedge clk);
      check_outs("reset_mid_rise", 1'b1, 1'b1, 1'b0, 1);

      // Edge counter wrap.
      d_raw = 1'b0;
      do_reset();
      hold(1'b0, 4);
      for (int i = 0; i < 5; i++) begin
         hold(1'b1, 6);
         check($sformatf("wrap%0d", i), edge_count, 32'(wrap_exp[i]));
         hold(1'b0, 8);
      end

      // Randomized stimulus with occasional asynchronous resets.
      repeat (400) begin
         if ($urandom_range(0, 39) == 0) begin
            @(posedge clk);
            #0.3 reset_n = 1'b0;
            repeat ($urandom_range(1, 3)) @(negedge clk);
            reset_n = 1'b1;
         end
         @(negedge clk);
         #(0.1 * $urandom_range(0, 4));
         d_raw = 1'($urandom_range(0, 1));
         repeat ($urandom_range(0, 8)) @(negedge clk);
      end
      repeat (12) @(negedge clk);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
